// File: rtl/bist_pkg.sv
// Shared types and polynomial helpers for the BIST pattern controller.
// LFSR x^35+x^33+1 drives patterns; MISR x^24+x^23+x^22+x^17+1 compacts responses.
package bist_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SEED,
      RUN,
      CMP,
      DONE
   } state_t;

   localparam int LFSR_W = 35;
   localparam int MISR_W = 24;

   localparam int LFSR_TAP_A = 35;
   localparam int LFSR_TAP_B = 33;

   localparam int MISR_TAP_A = 24;
   localparam int MISR_TAP_B = 23;
   localparam int MISR_TAP_C = 22;
   localparam int MISR_TAP_D = 17;

   function automatic logic [LFSR_W-1:0] lfsr_next(
      input logic [LFSR_W-1:0] s
   );
      return {s[LFSR_W-2:0],
              s[LFSR_TAP_A-1] ^ s[LFSR_TAP_B-1]};
   endfunction

   function automatic logic [MISR_W-1:0] misr_next(
      input logic [MISR_W-1:0] s,
      input logic [MISR_W-1:0] d
   );
      logic fb;
      fb = s[MISR_TAP_A-1] ^ s[MISR_TAP_B-1]
         ^ s[MISR_TAP_C-1] ^ s[MISR_TAP_D-1];
      return {s[MISR_W-2:0], fb} ^ d;
   endfunction

endpackage

// File: rtl/bist_pattern_ctrl_if.sv
// Bus between the test top / core and the BIST pattern controller.
// master = test top and core side, slave = controller side.
interface bist_pattern_ctrl_if #(
   parameter int PI_W = 35,
   parameter int PO_W = 24
);
   logic            START;
   logic            ABORT;
   logic [PI_W-1:0] DUT_PI;
   logic [PO_W-1:0] DUT_PO;
   logic            BUSY;
   logic            DONE;
   logic            PASS;
   logic [PO_W-1:0] SIGNATURE;
   logic [15:0]     PAT_CNT;

   modport master (
      output START, ABORT, DUT_PO,
      input  DUT_PI, BUSY, DONE, PASS, SIGNATURE, PAT_CNT
   );

   modport slave (
      input  START, ABORT, DUT_PO,
      output DUT_PI, BUSY, DONE, PASS, SIGNATURE, PAT_CNT
   );
endinterface

// File: rtl/bist_misr.sv
// 24-bit multiple-input signature register with synchronous load and enable.
// Load takes priority over compaction.
module bist_misr
   import bist_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              en,
   input  logic [MISR_W-1:0] seed,
   input  logic [MISR_W-1:0] d,
   output logic [MISR_W-1:0] sig
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sig <= '0;
      end else if (load) begin
         sig <= seed;
      end else if (en) begin
         sig <= misr_next(sig, d);
      end
   end

endmodule

// File: rtl/bist_pattern_ctrl.sv
// BIST controller: LFSR patterns into the core, MISR compaction of its outputs,
// final signature compare against GOLDEN after NPAT patterns.
module bist_pattern_ctrl
   import bist_pkg::*;
#(
   parameter int          PI_W      = 35,
   parameter int          PO_W      = 24,
   parameter int unsigned NPAT      = 1024,
   parameter logic [34:0] LFSR_SEED = 35'h1,
   parameter logic [23:0] MISR_SEED = 24'h0,
   parameter logic [23:0] GOLDEN    = 24'h0
) (
   input logic                CK,
   input logic                RST,
   bist_pattern_ctrl_if.slave bus
);

   if (NPAT < 1) begin : g_npat_chk
      $error("bist_pattern_ctrl: NPAT must be >= 1");
   end

   // all-zero seed would lock the LFSR
   localparam logic [PI_W-1:0] SEED_EFF =
      (LFSR_SEED == '0) ? PI_W'(1) : PI_W'(LFSR_SEED);
   localparam logic [31:0] LAST = 32'(NPAT - 1);

   state_t            state;
   state_t            nxt;
   logic [PI_W-1:0]   lfsr;
   logic [31:0]       run_cnt;
   logic [15:0]       pat_cnt;
   logic              pass;
   logic [PO_W-1:0]   sig;
   logic              go;
   logic              abort_any;
   logic              last;

   assign go        = bus.START & ~bus.ABORT;
   assign abort_any = bus.ABORT & (state != IDLE);
   assign last      = (run_cnt == LAST);

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:    if (go) nxt = SEED;
         DONE:    if (go) nxt = SEED;
         SEED:    nxt = RUN;
         RUN:     if (last) nxt = CMP;
         CMP:     nxt = DONE;
         default: nxt = IDLE;
      endcase
      if (abort_any) nxt = IDLE;
   end

   always_ff @(posedge CK or posedge RST) begin
      if (RST) state <= IDLE;
      else     state <= nxt;
   end

   // run_cnt ends the run; pat_cnt is the saturating visible count
   always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
         lfsr    <= '0;
         run_cnt <= '0;
         pat_cnt <= '0;
         pass    <= 1'b0;
      end else if (abort_any) begin
         lfsr <= '0;
         pass <= 1'b0;
      end else begin
         case (state)
            SEED: begin
               lfsr    <= SEED_EFF;
               run_cnt <= '0;
               pat_cnt <= '0;
               pass    <= 1'b0;
            end
            RUN: begin
               lfsr    <= lfsr_next(lfsr);
               run_cnt <= run_cnt + 32'd1;
               if (pat_cnt != 16'hFFFF)
                  pat_cnt <= pat_cnt + 16'd1;
            end
            CMP: pass <= (sig == GOLDEN);
            default: ;
         endcase
      end
   end

   bist_misr u_misr (
      .clk  (CK),
      .rst  (RST),
      .load ((state == SEED) & ~abort_any),
      .en   ((state == RUN) & ~abort_any),
      .seed (MISR_SEED),
      .d    (bus.DUT_PO),
      .sig  (sig)
   );

   assign bus.DUT_PI    = lfsr;
   assign bus.BUSY      = (state == SEED) | (state == RUN)
                        | (state == CMP);
   assign bus.DONE      = (state == DONE);
   assign bus.PASS      = pass;
   assign bus.SIGNATURE = sig;
   assign bus.PAT_CNT   = pat_cnt;

endmodule
